sr_fetch: RTL and testbench

//  Instruction fetch stage feeding sr_decode: owns the PC and issues word reads to
//  an instruction memory with variable, in-order latency. Returned words are buffered
//  in a small FIFO and presented as {instr, pc} over a valid/ready handshake.

---
 rtl/sr_fetch_pkg.sv | 13 +
 rtl/sr_fetch_fifo.sv | 49 ++++
 rtl/sr_fetch.sv | 115 +++++++++++
 tb/tb_sr_fetch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_fetch_pkg.sv
// Shared constants and types for the sr_fetch instruction fetch stage.
// Holds the bubble encoding, PC increment and the buffered {pc, instr} entry layout.
package sr_fetch_pkg;

    localparam logic [31:0] SR_INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] SR_PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sr_fetch_fifo.sv
// Synchronous FIFO buffering fetched {pc, instr} entries for sr_fetch.
// Flush takes priority over a push in the same cycle; head is read from registered storage.
module sr_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sr_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem reads, buffers responses.
// Optional perf counters (perf_fetched, perf_stall) exist only when SR_FETCH_PERF_EN is defined.
module sr_fetch
    import sr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef SR_FETCH_PERF_EN
   ,output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic          req_fire;
    logic          rsp_ok;
    logic          rsp_keep;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Credit covers both in-flight requests and buffered entries so a response always has a slot.
    assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && !fifo_full
                            && (inflight < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_ok          = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep        = rsp_ok && (drop == '0) && !redirect_valid;
    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_ok);

    assign pop        = out_valid && out_ready;
    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                pc     <= redirect_pc & ~32'h3;
                rsp_pc <= redirect_pc & ~32'h3;
                drop   <= outstanding_nxt;
            end else begin
                if (req_fire) pc <= pc + SR_PC_STEP;
                if (rsp_ok) begin
                    if (drop != '0) drop   <= drop - 1'b1;
                    else            rsp_pc <= rsp_pc + SR_PC_STEP;
                end
            end
        end
    end

    sr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = head.pc;
    assign out_instr = out_valid ? head.instr : SR_INSTR_NOP;

`ifdef SR_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop)                     perf_fetched <= perf_fetched + 32'd1;
            if (out_ready && !out_valid) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_fetch.sv
// Scoreboard bench for sr_fetch: a latency-configurable memory model feeds the DUT,
// issued fetches queue expected {pc, instr}, and a monitor checks what reaches decode.
module tb_sr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef SR_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    sr_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef SR_FETCH_PERF_EN
       ,.perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } pend_t;

    exp_t        expq[$];
    pend_t       pend[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_hs  = 0;
    int unsigned cyc   = 0;
    logic [31:0] tb_pc = RESET_PC;
    logic        prev_rst;
    logic        prev_redir;

    // Stimulus knobs applied by step() each cycle.
    logic        k_rst = 1'b1;
    logic        k_redir = 1'b0;
    logic [31:0] k_redir_pc = '0;
    logic        k_ordy = 1'b1;
    logic        k_rdy = 1'b1;
    logic        k_rand = 1'b0;
    logic        k_spur = 1'b0;
    int unsigned k_lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h00A5_5A00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic  give;
        pend_t p;
        @(negedge clk);
        cyc++;
        prev_rst       = rst;
        prev_redir     = redirect_valid;
        rst            = k_rst;
        redirect_valid = k_redir;
        redirect_pc    = k_redir_pc;
        out_ready      = k_ordy;
        imem_req_ready = k_rand ? 1'($urandom_range(0, 1)) : k_rdy;
        give = 1'b0;
        if (k_spur) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (!k_rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
            give = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (rst) begin
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            pend.delete();
            tb_pc = RESET_PC;
        end else begin
            if (prev_rst) begin
                chk("first_req_after_rst", 64'(imem_req_valid), 64'd1);
                chk("out_valid_after_rst", 64'(out_valid), 64'd0);
            end
            if (prev_redir)     chk("out_valid_after_redirect", 64'(out_valid), 64'd0);
            if (redirect_valid) chk("req_valid_during_redirect", 64'(imem_req_valid), 64'd0);
            if (give) void'(pend.pop_front());
            if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(tb_pc));
            if (imem_req_valid && imem_req_ready) begin
                p.due  = cyc + k_lat;
                p.data = mem_word(tb_pc);
                pend.push_back(p);
                expq.push_back('{pc: tb_pc, instr: mem_word(tb_pc)});
                tb_pc += 32'd4;
            end
        end
        #2;
        if (rst) begin
            expq.delete();
        end else if (redirect_valid) begin
            expq.delete();
            tb_pc = redirect_pc & ~32'h3;
        end
    endtask

    // Monitor: pops the scoreboard on each decode handshake.
    initial begin
        logic        prev_hold = 1'b0;
        logic [31:0] hold_pc   = '0;
        int unsigned wait_cnt  = 0;
        exp_t        e;
`ifdef SR_FETCH_PERF_EN
        logic [31:0] m_fetched = '0;
        logic [31:0] m_stall   = '0;
        logic        perf_ok   = 1'b0;
`endif
        forever begin
            @(negedge clk);
            #2;
`ifdef SR_FETCH_PERF_EN
            if (perf_ok) begin
                chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
                chk("perf_stall", 64'(perf_stall), 64'(m_stall));
            end
            if (rst) begin
                m_fetched = '0;
                m_stall   = '0;
                perf_ok   = 1'b1;
            end else begin
                if (out_valid && out_ready)  m_fetched += 32'd1;
                if (out_ready && !out_valid) m_stall   += 32'd1;
            end
`endif
            if (rst) begin
                prev_hold = 1'b0;
                wait_cnt  = 0;
            end else begin
                if (prev_hold) begin
                    chk("hold_out_valid", 64'(out_valid), 64'd1);
                    chk("hold_out_pc", 64'(out_pc), 64'(hold_pc));
                end
                prev_hold = out_valid && !out_ready && !redirect_valid;
                hold_pc   = out_pc;
                if (out_valid && out_ready) begin
                    n_hs++;
                    wait_cnt = 0;
                    if (expq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_out: got pc %h instr %h, want no output (cycle %0d)",
                                 out_pc, out_instr, cyc);
                    end else begin
                        e = expq.pop_front();
                        chk("out_pc", 64'(out_pc), 64'(e.pc));
                        chk("out_instr", 64'(out_instr), 64'(e.instr));
                    end
                end else if (out_ready && expq.size() > 0) begin
                    wait_cnt++;
                    if (wait_cnt > 40) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL out_timeout: got no output for 40 cycles, want pc %h", expq[0].pc);
                        wait_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        int unsigned h0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;

        repeat (3) step();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_req_valid", 64'(imem_req_valid), 64'd0);

        // Latency 1, full throughput.
        k_rst = 1'b0;
        repeat (6) step();
        h0 = n_hs;
        repeat (10) step();
        chk("throughput", 64'(n_hs - h0), 64'd10);

        // Decode back-pressure fills the credit window.
        k_ordy = 1'b0;
        repeat (10) step();
        chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        k_ordy = 1'b1;
        repeat (10) step();

        // Latency 3 with a misaligned redirect target.
        k_lat = 3;
        repeat (8) step();
        k_redir = 1'b1;
        k_redir_pc = 32'h103;
        step();
        k_redir = 1'b0;
        repeat (30) step();

        // Redirect landing on a response cycle, then immediately redirected again.
        for (int i = 0; i < 10 && !(pend.size() > 0 && pend[0].due <= cyc + 1); i++) step();
        k_redir = 1'b1;
        k_redir_pc = 32'h180;
        step();
        k_redir_pc = 32'h200;
        step();
        k_redir = 1'b0;
        repeat (30) step();

        // Randomly stalled memory request channel.
        k_lat = 2;
        k_rand = 1'b1;
        repeat (60) step();
        k_rand = 1'b0;

        // Spurious response with nothing outstanding.
        k_rdy = 1'b0;
        repeat (15) step();
        k_spur = 1'b1;
        step();
        k_spur = 1'b0;
        repeat (5) step();
        chk("spurious_ignored", 64'(out_valid), 64'd0);
        k_rdy = 1'b1;
        repeat (20) step();

        // One-cycle reset mid-stream.
        k_ordy = 1'b0;
        k_rst = 1'b1;
        step();
        k_rst = 1'b0;
        k_ordy = 1'b1;
        repeat (25) step();

        // Drain: every issued, non-flushed fetch must have been delivered.
        k_rdy = 1'b0;
        repeat (20) step();
        chk("drain_empty", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
